riscv_tlb_ptw: RTL and testbench

//  Parametrised Sv32 translation unit: N-entry fully-associative TLB with 4K/4M page support plus hardware

---
 rtl/riscv_tlb_ptw_pkg.sv | 60 ++++++
 rtl/riscv_tlb_ptw_if.sv | 40 ++++
 rtl/riscv_tlb_cam.sv | 107 ++++++++++
 rtl/riscv_tlb_ptw.sv | 181 ++++++++++++++++++
 tb/tb_riscv_tlb_ptw.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_tlb_ptw_pkg.sv
// Shared types and helpers for the Sv32 TLB and page-table walker.
// PTE flag indices, satp fields, privilege/access codes, walker states.
package riscv_tlb_ptw_pkg;

    localparam int PAGE_V = 0;
    localparam int PAGE_R = 1;
    localparam int PAGE_W = 2;
    localparam int PAGE_X = 3;
    localparam int PAGE_U = 4;
    localparam int PAGE_G = 5;
    localparam int PAGE_A = 6;
    localparam int PAGE_D = 7;

    localparam int SATP_MODE = 31;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [1:0] ACC_LOAD  = 2'd0;
    localparam logic [1:0] ACC_STORE = 2'd1;
    localparam logic [1:0] ACC_EXEC  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_WAIT,
        ST_L2_REQ,
        ST_L2_WAIT,
        ST_CHECK,
        ST_FILL,
        ST_RESP
    } ptw_state_e;

    // Leaf permission check. A/D are never updated by hardware,
    // so a clear A, or a store to a clean page, faults.
    function automatic logic perm_fault(
        input logic [7:0] f,
        input logic [1:0] acc,
        input logic [1:0] priv,
        input logic       sum,
        input logic       mxr
    );
        logic base;
        logic u_bad;
        unique case (1'b1)
            acc == ACC_EXEC:  base = !f[PAGE_X];
            acc == ACC_STORE: base = !f[PAGE_W] | !f[PAGE_D];
            default:          base = !(f[PAGE_R] | (mxr & f[PAGE_X]));
        endcase
        if (priv == PRIV_U)
            u_bad = !f[PAGE_U];
        else if (acc == ACC_EXEC)
            u_bad = f[PAGE_U];
        else
            u_bad = f[PAGE_U] & !sum;
        return base | u_bad | !f[PAGE_A];
    endfunction

endpackage

// File: rtl/riscv_tlb_ptw_if.sv
// Core request/response channel plus walker memory port.
// slave: translation unit side; master: core + memory side.
interface riscv_tlb_ptw_if #(
    parameter int TAG_W = 11
) ();
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_vaddr;
    logic [1:0]       req_acc;
    logic             resp_valid;
    logic [31:0]      resp_paddr;
    logic             resp_pf;
    logic             resp_af;
    logic             mem_rd;
    logic [31:0]      mem_addr;
    logic [TAG_W-1:0] mem_tag;
    logic             mem_accept;
    logic             mem_ack;
    logic             mem_error;
    logic [31:0]      mem_rdata;
    logic [TAG_W-1:0] mem_resp_tag;

    modport slave (
        input  req_valid, req_vaddr, req_acc,
        input  mem_accept, mem_ack, mem_error,
        input  mem_rdata, mem_resp_tag,
        output req_ready, resp_valid, resp_paddr,
        output resp_pf, resp_af,
        output mem_rd, mem_addr, mem_tag
    );

    modport master (
        output req_valid, req_vaddr, req_acc,
        output mem_accept, mem_ack, mem_error,
        output mem_rdata, mem_resp_tag,
        input  req_ready, resp_valid, resp_paddr,
        input  resp_pf, resp_af,
        input  mem_rd, mem_addr, mem_tag
    );
endinterface

// File: rtl/riscv_tlb_cam.sv
// Fully-associative TLB entry array: lookup, victim select, fill, flush.
// Ports: clk, rst_n (async, asserted high), flush, cur_asid, lk_*, fill_*.
// TLB_ASID_EN: entries tagged with ASID/global; flush spares global/other ASIDs.
module riscv_tlb_cam
    import riscv_tlb_ptw_pkg::*;
#(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [8:0]  cur_asid,
    input  logic [31:0] lk_vaddr,
    output logic        lk_hit,
    output logic [19:0] lk_ppn,
    output logic [7:0]  lk_flags,
    output logic        lk_mega,
    input  logic        fill,
    input  logic [19:0] fill_vpn,
    input  logic        fill_mega,
    input  logic [19:0] fill_ppn,
    input  logic [7:0]  fill_flags
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  valid_q;
    logic [N-1:0]  mega_q;
    logic [19:0]   vpn_q [N];
    logic [19:0]   ppn_q [N];
    logic [7:0]    flg_q [N];
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] victim;
    logic [N-1:0]  hv;
    logic [N-1:0]  kill;

`ifdef TLB_ASID_EN
    logic [8:0] asid_q [N];
`else
    logic unused_asid;
    assign unused_asid = ^cur_asid;
`endif

    always_comb begin
        hv = '0;
        kill = '0;
        for (int i = 0; i < N; i++) begin
            // Superpages compare only VPN[1].
            hv[i] = valid_q[i] & (mega_q[i]
                ? vpn_q[i][19:10] == lk_vaddr[31:22]
                : vpn_q[i] == lk_vaddr[31:12]);
`ifdef TLB_ASID_EN
            hv[i] = hv[i] & ((asid_q[i] == cur_asid) | flg_q[i][PAGE_G]);
            kill[i] = !flg_q[i][PAGE_G] & (asid_q[i] == cur_asid);
`else
            kill[i] = 1'b1;
`endif
        end
    end

    always_comb begin
        lk_hit = 1'b0;
        lk_ppn = '0;
        lk_flags = '0;
        lk_mega = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hv[i]) begin
                lk_hit = 1'b1;
                lk_ppn = lk_ppn | ppn_q[i];
                lk_flags = lk_flags | flg_q[i];
                lk_mega = lk_mega | mega_q[i];
            end
        end
    end

    // Lowest free slot wins; round-robin pointer only when full.
    always_comb begin
        victim = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_q <= '0;
            ptr_q <= '0;
        end else if (flush) begin
            valid_q <= valid_q & ~kill;
        end else if (fill) begin
            valid_q[victim] <= 1'b1;
            ptr_q <= ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !flush) begin
            vpn_q[victim] <= fill_vpn;
            ppn_q[victim] <= fill_ppn;
            flg_q[victim] <= fill_flags;
            mega_q[victim] <= fill_mega;
`ifdef TLB_ASID_EN
            asid_q[victim] <= cur_asid;
`endif
        end
    end

endmodule

// File: rtl/riscv_tlb_ptw.sv
// Sv32 translation unit: TLB lookup, bypass, hardware page-table walker.
// Ports: clk, rst_n (async, asserted high), flush_tlb, satp_val, priv_lvl,
// sum_en, mxr_en, bus (riscv_tlb_ptw_if.slave). Option: TLB_ASID_EN.
module riscv_tlb_ptw
    import riscv_tlb_ptw_pkg::*;
#(
    parameter int               TLB_ENTRIES = 8,
    parameter int               TAG_W       = 11,
    parameter logic [TAG_W-1:0] PTW_TAG     = TAG_W'(11'h380)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_tlb,
    input  logic [31:0] satp_val,
    input  logic [1:0]  priv_lvl,
    input  logic        sum_en,
    input  logic        mxr_en,
    riscv_tlb_ptw_if.slave bus
);
    ptw_state_e state_q, state_d;

    logic [31:0] va_q, pte_q;
    logic [1:0]  acc_q;
    logic        mega_q, pf_q, af_q, flush_seen_q;
    logic        lk_hit, lk_mega, fill;
    logic [19:0] lk_ppn;
    logic [7:0]  lk_flags;

    wire bypass = !satp_val[SATP_MODE] | (priv_lvl == PRIV_M);
    wire accept = bus.req_valid & bus.req_ready;
    wire fast = bypass | lk_hit;

    // Only tags with [9:7]==3'b111 are walker responses.
    wire walk_ack = bus.mem_ack & (bus.mem_resp_tag[9:7] == 3'b111);
    wire [31:0] pte = bus.mem_rdata;
    wire pte_leaf = |pte[PAGE_X:PAGE_R];
    wire pte_bad = !pte[PAGE_V] | (pte[PAGE_W] & !pte[PAGE_R]);

    wire hit_pf = perm_fault(lk_flags, bus.req_acc,
                             priv_lvl, sum_en, mxr_en);
    wire [31:0] hit_pa = lk_mega
        ? {lk_ppn[19:10], bus.req_vaddr[21:0]}
        : {lk_ppn, bus.req_vaddr[11:0]};

    wire chk_pf = perm_fault(pte_q[7:0], acc_q, priv_lvl, sum_en, mxr_en)
                | (mega_q & |pte_q[19:10]);
    wire [31:0] walk_pa = mega_q
        ? {pte_q[29:20], va_q[21:0]}
        : {pte_q[29:10], va_q[11:0]};

    wire [31:0] l1_addr = {satp_val[19:0], 12'h000}
                        + {20'h0, va_q[31:22], 2'b00};
    wire [31:0] l2_addr = {pte_q[29:10], 12'h000}
                        + {20'h0, va_q[21:12], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{satp_val[30:20], pte_q[31:30],
                           pte_q[9:8], bus.mem_resp_tag};

    riscv_tlb_cam #(.N(TLB_ENTRIES)) u_cam (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_tlb),
        .cur_asid   (satp_val[30:22]),
        .lk_vaddr   (bus.req_vaddr),
        .lk_hit     (lk_hit),
        .lk_ppn     (lk_ppn),
        .lk_flags   (lk_flags),
        .lk_mega    (lk_mega),
        .fill       (fill),
        .fill_vpn   (va_q[31:12]),
        .fill_mega  (mega_q),
        .fill_ppn   (pte_q[29:10]),
        .fill_flags (pte_q[7:0])
    );

    assign bus.req_ready = (state_q == ST_IDLE) & !rst_n;
    assign bus.mem_tag = PTW_TAG;

    always_comb begin
        state_d = state_q;
        fill = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_addr = '0;
        unique case (state_q)
            ST_IDLE: if (accept && !fast) state_d = ST_L1_REQ;
            ST_L1_REQ: begin
                bus.mem_rd = 1'b1;
                bus.mem_addr = l1_addr;
                if (bus.mem_accept) state_d = ST_L1_WAIT;
            end
            ST_L1_WAIT: if (walk_ack) begin
                if (bus.mem_error || pte_bad) state_d = ST_RESP;
                else if (pte_leaf) state_d = ST_CHECK;
                else state_d = ST_L2_REQ;
            end
            ST_L2_REQ: begin
                bus.mem_rd = 1'b1;
                bus.mem_addr = l2_addr;
                if (bus.mem_accept) state_d = ST_L2_WAIT;
            end
            ST_L2_WAIT: if (walk_ack) begin
                if (bus.mem_error || pte_bad || !pte_leaf)
                    state_d = ST_RESP;
                else
                    state_d = ST_CHECK;
            end
            ST_CHECK: state_d = chk_pf ? ST_RESP : ST_FILL;
            ST_FILL: begin
                // A flush seen at any point in the walk drops the fill.
                fill = !flush_tlb & !flush_seen_q;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            va_q <= '0;
            acc_q <= '0;
            pte_q <= '0;
            mega_q <= 1'b0;
            pf_q <= 1'b0;
            af_q <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            flush_seen_q <= flush_seen_q | flush_tlb;
            if (accept) begin
                va_q <= bus.req_vaddr;
                acc_q <= bus.req_acc;
                pf_q <= 1'b0;
                af_q <= 1'b0;
                mega_q <= 1'b0;
                flush_seen_q <= 1'b0;
            end
            if (state_q == ST_L1_WAIT && walk_ack) begin
                pte_q <= pte;
                af_q <= bus.mem_error;
                pf_q <= !bus.mem_error & pte_bad;
                mega_q <= pte_leaf;
            end
            if (state_q == ST_L2_WAIT && walk_ack) begin
                pte_q <= pte;
                af_q <= bus.mem_error;
                pf_q <= !bus.mem_error & (pte_bad | !pte_leaf);
            end
            if (state_q == ST_CHECK) pf_q <= chk_pf;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_paddr <= '0;
            bus.resp_pf <= 1'b0;
            bus.resp_af <= 1'b0;
        end else begin
            bus.resp_valid <= (accept & fast) | (state_q == ST_RESP);
            bus.resp_pf <= 1'b0;
            bus.resp_af <= 1'b0;
            if (accept && bypass) begin
                bus.resp_paddr <= bus.req_vaddr;
            end else if (accept && lk_hit) begin
                bus.resp_paddr <= hit_pa;
                bus.resp_pf <= hit_pf;
            end else if (state_q == ST_RESP) begin
                bus.resp_paddr <= walk_pa;
                bus.resp_pf <= pf_q;
                bus.resp_af <= af_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_tlb_ptw.sv
// Self-checking bench for riscv_tlb_ptw: directed steps plus random traffic
// compared against a page-table / TLB reference model.
module tb_riscv_tlb_ptw;
    import riscv_tlb_ptw_pkg::*;

    localparam int N = 8;
    localparam logic [31:0] ROOT = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush_main, flush_r, flush_tlb;
    logic [31:0] satp;
    logic [1:0]  priv;
    logic        sum_en, mxr_en;
    assign flush_tlb = flush_main | flush_r;

    riscv_tlb_ptw_if #(.TAG_W(11)) bus ();

    riscv_tlb_ptw #(.TLB_ENTRIES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_tlb (flush_tlb),
        .satp_val  (satp),
        .priv_lvl  (priv),
        .sum_en    (sum_en),
        .mxr_en    (mxr_en),
        .bus       (bus)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] pt [logic [31:0]];

    typedef struct {
        bit          v;
        bit          mega;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic [7:0]  fl;
    } ment_t;
    ment_t mt [N];
    int mptr = 0;

    int rd_total = 0;
    int rd_base = 0;
    bit err_once = 0;
    bit foreign_once = 0;
    bit flush_in_l2 = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic void map4k(logic [31:0] va, logic [19:0] ppn,
                                  logic [7:0] fl);
        logic [31:0] l2base;
        l2base = 32'h0010_0000 + {10'h0, va[31:22], 12'h000};
        pt[ROOT + {20'h0, va[31:22], 2'b00}] =
            {2'b00, l2base[31:12], 2'b00, 8'h01};
        pt[l2base + {20'h0, va[21:12], 2'b00}] = {2'b00, ppn, 2'b00, fl};
    endfunction

    function automatic void map4m(logic [31:0] va, logic [31:0] p);
        pt[ROOT + {20'h0, va[31:22], 2'b00}] = p;
    endfunction

    function automatic logic [31:0] rd_pt(logic [31:0] a);
        return pt.exists(a) ? pt[a] : 32'h0;
    endfunction

    // Permission rules: priv 0 = U, 1 = S; acc 0 load, 1 store, 2 exec.
    function automatic bit m_fault(logic [7:0] f, int acc, int pr,
                                   bit sm, bit mx);
        bit r, w, x, u, a, d;
        r = f[1]; w = f[2]; x = f[3]; u = f[4]; a = f[6]; d = f[7];
        if (!a) return 1;
        if (acc == 2) begin
            if (!x) return 1;
            return (pr == 0) ? !u : u;
        end
        if (acc == 1 && !(w && d)) return 1;
        if (acc != 1 && !(r || (mx && x))) return 1;
        if (pr == 0) return !u;
        return u && !sm;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < N; i++) mt[i].v = 0;
    endfunction

    function automatic void m_install(logic [31:0] va, bit mg,
                                      logic [19:0] ppn, logic [7:0] fl);
        int vic;
        vic = -1;
        for (int i = 0; i < N; i++)
            if (!mt[i].v && vic < 0) vic = i;
        if (vic < 0) begin
            vic = mptr;
            mptr = (mptr + 1) % N;
        end else begin
            mptr = (mptr + 1) % N;
        end
        mt[vic].v = 1;
        mt[vic].mega = mg;
        mt[vic].vpn = va[31:12];
        mt[vic].ppn = ppn;
        mt[vic].fl = fl;
    endfunction

    task automatic predict(input logic [31:0] va, input int acc,
                           output logic [31:0] pa, output bit pf,
                           output bit af, output int reads,
                           output bit fast);
        logic [31:0] p1, p2;
        bit hit;
        pa = 0; pf = 0; af = 0; reads = 0; fast = 0; hit = 0;
        if (!satp[31] || priv == 2'd3) begin
            pa = va;
            fast = 1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && mt[i].v && (mt[i].mega
                    ? mt[i].vpn[19:10] == va[31:22]
                    : mt[i].vpn == va[31:12])) begin
                hit = 1;
                fast = 1;
                pf = m_fault(mt[i].fl, acc, priv, sum_en, mxr_en);
                pa = mt[i].mega ? {mt[i].ppn[19:10], va[21:0]}
                                : {mt[i].ppn, va[11:0]};
            end
        end
        if (hit) return;
        reads = 1;
        p1 = rd_pt({satp[19:0], 12'h0} + va[31:22] * 4);
        if (err_once) begin
            af = 1;
            return;
        end
        if (!p1[0] || (p1[2] && !p1[1])) begin
            pf = 1;
            return;
        end
        if (p1[3:1] != 0) begin
            pa = {p1[29:20], va[21:0]};
            pf = m_fault(p1[7:0], acc, priv, sum_en, mxr_en)
                 || p1[19:10] != 0;
            if (!pf) m_install(va, 1, p1[29:10], p1[7:0]);
            return;
        end
        reads = 2;
        p2 = rd_pt({p1[29:10], 12'h0} + va[21:12] * 4);
        if (flush_in_l2) m_flush();
        if (!p2[0] || (p2[2] && !p2[1]) || p2[3:1] == 0) begin
            pf = 1;
            return;
        end
        pa = {p2[29:10], va[11:0]};
        pf = m_fault(p2[7:0], acc, priv, sum_en, mxr_en);
        if (!pf && !flush_in_l2) m_install(va, 0, p2[29:10], p2[7:0]);
    endtask

    task automatic do_req(string nm, logic [31:0] va, int acc);
        logic [31:0] pa;
        bit pf, af, fast;
        int reads, w, lat;
        predict(va, acc, pa, pf, af, reads, fast);
        rd_base = rd_total;
        @(negedge clk);
        bus.req_vaddr = va;
        bus.req_acc = 2'(acc);
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_accept"}, 32'(w < 200), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_resp"}, 32'(bus.resp_valid), 1);
        if (fast) check({nm, "_lat"}, lat, 1);
        check({nm, "_pf"}, 32'(bus.resp_pf), 32'(pf));
        check({nm, "_af"}, 32'(bus.resp_af), 32'(af));
        if (!pf && !af) check({nm, "_pa"}, bus.resp_paddr, pa);
        check({nm, "_reads"}, rd_total - rd_base, reads);
        @(negedge clk);
        check({nm, "_pulse"}, 32'(bus.resp_valid), 0);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush_main = 1'b1;
        @(negedge clk);
        flush_main = 1'b0;
        m_flush();
    endtask

    // Memory port responder for walker reads.
    initial begin
        bus.mem_accept = 0;
        bus.mem_ack = 0;
        bus.mem_error = 0;
        bus.mem_rdata = 0;
        bus.mem_resp_tag = 0;
        flush_r = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd) begin
                int idx;
                logic [31:0] a;
                a = bus.mem_addr;
                rd_total++;
                idx = rd_total - rd_base;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.mem_accept = 1;
                @(negedge clk);
                bus.mem_accept = 0;
                if (flush_in_l2 && idx == 2) begin
                    flush_r = 1;
                    @(negedge clk);
                    flush_r = 0;
                end
                if (foreign_once && idx == 1) begin
                    bus.mem_ack = 1;
                    bus.mem_resp_tag = 11'h005;
                    bus.mem_rdata = 0;
                    @(negedge clk);
                    bus.mem_ack = 0;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.mem_ack = 1;
                bus.mem_resp_tag = 11'h380 | 11'($urandom_range(0, 127));
                bus.mem_error = err_once && idx == 1;
                bus.mem_rdata = rd_pt(a);
                @(negedge clk);
                bus.mem_ack = 0;
                bus.mem_error = 0;
            end
        end
    end

    initial begin
        logic [31:0] pool [12];
        rst_n = 1'b1;
        flush_main = 0;
        satp = 0;
        priv = 2'd1;
        sum_en = 0;
        mxr_en = 0;
        bus.req_valid = 0;
        bus.req_vaddr = 0;
        bus.req_acc = 0;
        m_flush();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_mem_rd", 32'(bus.mem_rd), 0);
        check("rst_paddr", bus.resp_paddr, 0);
        check("rst_pf_af", {bus.resp_pf, bus.resp_af}, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 1);
        check("mem_tag", 32'(bus.mem_tag), 32'h380);

        do_req("bypass", 32'h8000_1234, 0);

        satp = {1'b1, 9'd0, 22'h10};
        map4k(32'h0040_5678, 20'h80000, 8'hCF);
        do_req("walk2", 32'h0040_5678, 0);
        do_req("hit2", 32'h0040_5ABC, 0);

        map4m(32'h00C0_0000, 32'h2000_00CF);
        do_req("mega", 32'h00C1_2345, 0);
        map4m(32'h0100_0000, 32'h2000_04CF);
        do_req("misalign", 32'h0100_0010, 0);

        priv = 2'd0;
        map4k(32'h0140_0000, 20'h12345, 8'h57);
        do_req("u_st_clean", 32'h0140_0004, 1);
        do_req("u_st_again", 32'h0140_0008, 1);
        priv = 2'd1;
        map4k(32'h0180_0000, 20'h23456, 8'hDF);
        do_req("s_nosum", 32'h0180_0100, 0);
        sum_en = 1;
        do_req("s_sum", 32'h0180_0100, 0);
        sum_en = 0;

        flush_pulse();
        for (int i = 0; i <= N; i++) begin
            map4k({10'(16 + i), 22'h0}, 20'h30000 + 20'(i), 8'hCF);
            do_req("fill", {10'(16 + i), 22'h0}, 0);
        end
        do_req("evicted", {10'(16), 22'h0}, 0);

        map4k(32'h0800_0000, 20'h44444, 8'hCF);
        flush_in_l2 = 1;
        do_req("flush_l2", 32'h0800_0040, 0);
        flush_in_l2 = 0;
        do_req("after_flush", 32'h0800_0040, 0);

        map4k(32'h0840_0000, 20'h55555, 8'hCF);
        err_once = 1;
        do_req("bus_err", 32'h0840_0000, 0);
        err_once = 0;
        map4k(32'h0880_0000, 20'h66666, 8'hCF);
        foreign_once = 1;
        do_req("foreign", 32'h0880_0ABC, 2);
        foreign_once = 0;

        for (int i = 0; i < 12; i++) begin
            logic [7:0] fl;
            logic [7:0] fls [7];
            fls = '{8'hCF, 8'hDF, 8'h57, 8'h4B, 8'hC7, 8'h8F, 8'h45};
            fl = fls[$urandom_range(0, 6)];
            pool[i] = {10'(64 + i), 22'($urandom)};
            if (i % 3 == 0)
                map4m(pool[i], {2'b00, 10'($urandom), 10'h0, 2'b00, fl});
            else
                map4k(pool[i], 20'($urandom), fl);
        end
        for (int k = 0; k < 60; k++) begin
            int p;
            int pr [3];
            pr = '{0, 1, 3};
            p = $urandom_range(0, 11);
            priv = 2'(pr[$urandom_range(0, 2)]);
            sum_en = 1'($urandom);
            mxr_en = 1'($urandom);
            err_once = ($urandom_range(0, 9) == 0);
            foreign_once = ($urandom_range(0, 4) == 0);
            flush_in_l2 = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) flush_pulse();
            do_req("rand", pool[p] ^ 32'($urandom_range(0, 4095)),
                   $urandom_range(0, 2));
            err_once = 0;
            foreign_once = 0;
            flush_in_l2 = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
